dmem_arbiter: RTL and testbench

Two-requester arbiter that shares the single data-memory port (dmem: asynchronous read, write on the clock edge) between the CPU data path (after MIO_BUS address decode) and a debug/loader master. It sits between MIO_BUS and dmem and is clocked by the CPU clock. It grants one owner per cycle with round-robin fairness and optional bus locking for multi-beat sequences. It also drives the dmem write-enable, byte-mask, address and write-data from the current owner.

---
 rtl/dmem_arbiter.sv | 111 +++++++++++
 tb/tb_dmem_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter that shares the single dmem port between two masters, with optional bus lock.
// Build macro DMEM_ARB_TIMEOUT_EN bounds lock hold time to MAX_LOCK beats under contention.
module dmem_arbiter #(
  parameter int AW       = 7,
  parameter int MAX_LOCK = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          lock0,
  input  logic          lock1,
  input  logic          we0,
  input  logic          we1,
  input  logic [3:0]    amp0,
  input  logic [3:0]    amp1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [31:0]   wd0,
  input  logic [31:0]   wd1,
  output logic          gnt0,
  output logic          gnt1,
  output logic [31:0]   rd,
  output logic          ram_we,
  output logic [3:0]    ram_amp,
  output logic [AW-1:0] ram_addr,
  output logic [31:0]   ram_wd,
  input  logic [31:0]   ram_rd,
  output logic          lock_abort
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t state;
  logic   last;      // last master served; 1 after reset so master 0 wins the first tie
  logic   force_sw;
  logic   cur_lock;

  // Port mux is driven from the registered grants, so req/lock never reach gnt combinationally.
  always_comb begin
    rd       = ram_rd;
    ram_we   = (gnt0 & req0 & we0) | (gnt1 & req1 & we1);
    ram_amp  = gnt1 ? amp1  : amp0;
    ram_addr = gnt1 ? addr1 : addr0;
    ram_wd   = gnt1 ? wd1   : wd0;
  end

  assign cur_lock = (state == OWN1) ? lock1 : lock0;

`ifdef DMEM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(MAX_LOCK + 1);
  logic [CW-1:0] lock_cnt;
  logic          contend;

  assign contend  = (state != IDLE) && req0 && req1;
  assign force_sw = contend && (lock_cnt == CW'(MAX_LOCK - 1));

  // Counts locked beats held against a waiting master; any handover or idle other side clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      lock_cnt <= '0;
    else if (contend && cur_lock && !force_sw)
      lock_cnt <= lock_cnt + 1'b1;
    else
      lock_cnt <= '0;
  end
`else
  assign force_sw = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      last       <= 1'b1;
      lock_abort <= 1'b0;
    end else begin
      lock_abort <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 && (!req1 || last)) begin
            state <= OWN0; gnt0 <= 1'b1; gnt1 <= 1'b0; last <= 1'b0;
          end else if (req1) begin
            state <= OWN1; gnt0 <= 1'b0; gnt1 <= 1'b1; last <= 1'b1;
          end
        end
        OWN0: begin
          if (req1 && (!req0 || !lock0 || force_sw)) begin
            state <= OWN1; gnt0 <= 1'b0; gnt1 <= 1'b1; last <= 1'b1;
            lock_abort <= force_sw && cur_lock;
          end else if (!req0) begin
            state <= IDLE; gnt0 <= 1'b0; gnt1 <= 1'b0;
          end
        end
        OWN1: begin
          if (req0 && (!req1 || !lock1 || force_sw)) begin
            state <= OWN0; gnt0 <= 1'b1; gnt1 <= 1'b0; last <= 1'b0;
            lock_abort <= force_sw && cur_lock;
          end else if (!req1) begin
            state <= IDLE; gnt0 <= 1'b0; gnt1 <= 1'b0;
          end
        end
        default: begin
          state <= IDLE; gnt0 <= 1'b0; gnt1 <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus random traffic against a behavioural model.
module tb_dmem_arbiter;
  localparam int AW       = 7;
  localparam int MAX_LOCK = 16;
  localparam int DEPTH    = 1 << AW;

  logic          clk, rst;
  logic          req0, req1, lock0, lock1, we0, we1;
  logic [3:0]    amp0, amp1;
  logic [AW-1:0] addr0, addr1;
  logic [31:0]   wd0, wd1;
  logic          gnt0, gnt1, ram_we, lock_abort;
  logic [31:0]   rd, ram_wd, ram_rd;
  logic [3:0]    ram_amp;
  logic [AW-1:0] ram_addr;

  dmem_arbiter #(.AW(AW), .MAX_LOCK(MAX_LOCK)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
    .we0(we0), .we1(we1), .amp0(amp0), .amp1(amp1),
    .addr0(addr0), .addr1(addr1), .wd0(wd0), .wd1(wd1),
    .gnt0(gnt0), .gnt1(gnt1), .rd(rd),
    .ram_we(ram_we), .ram_amp(ram_amp), .ram_addr(ram_addr), .ram_wd(ram_wd),
    .ram_rd(ram_rd), .lock_abort(lock_abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural dmem: async read, byte-masked write on the rising edge.
  logic [31:0] mem [DEPTH];
  assign ram_rd = mem[ram_addr];
  always @(posedge clk)
    if (ram_we)
      for (int b = 0; b < 4; b++)
        if (ram_amp[b]) mem[ram_addr][8*b +: 8] <= ram_wd[8*b +: 8];

  int checks = 0;
  int failures = 0;

  // Reference model: owner 0/1, or 2 when the port is free.
  int          m_own = 2;
  int          m_last = 1;
  int          m_cnt = 0;
  bit          m_abort = 1'b0;
  logic [31:0] exp_mem [DEPTH];

  // Values seen in the most recent cycle, for directed checks.
  logic        s_gnt0, s_gnt1, s_we, s_abort;
  logic [31:0] s_rd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_own = 2; m_last = 1; m_cnt = 0; m_abort = 1'b0;
  endtask

  task automatic model_edge(input bit e_we, input int m);
    bit r [2];
    bit l [2];
    int x, y, nxt, beats;
    bit frc;
    if (e_we)
      for (int b = 0; b < 4; b++)
        if ((m ? amp1[b] : amp0[b]))
          exp_mem[m ? addr1 : addr0][8*b +: 8] = m ? wd1[8*b +: 8] : wd0[8*b +: 8];
    r[0] = req0; r[1] = req1; l[0] = lock0; l[1] = lock1;
    m_abort = 1'b0;
    if (m_own == 2) begin
      if (r[0] && r[1]) nxt = 1 - m_last;
      else if (r[0])    nxt = 0;
      else if (r[1])    nxt = 1;
      else              nxt = 2;
      m_cnt = 0;
    end else begin
      x = m_own; y = 1 - x; frc = 1'b0;
      beats = (r[x] && r[y]) ? m_cnt + 1 : 0;
`ifdef DMEM_ARB_TIMEOUT_EN
      frc = (beats >= MAX_LOCK);
`endif
      if (r[y] && (!r[x] || !l[x] || frc)) nxt = y;
      else if (!r[x])                      nxt = 2;
      else                                 nxt = x;
      m_abort = frc && r[x] && l[x];
      m_cnt = (nxt == x) ? beats : 0;
    end
    if (nxt != 2 && nxt != m_own) m_last = nxt;
    m_own = nxt;
  endtask

  // One clock cycle: inputs already set at the falling edge; compare, then advance the model.
  task automatic step();
    int m;
    bit e_we;
    logic [AW-1:0] ea;
    #1;
    m    = (m_own == 1) ? 1 : 0;
    e_we = (m_own == 0 && req0 && we0) || (m_own == 1 && req1 && we1);
    ea   = m ? addr1 : addr0;
    chk("gnt0", gnt0, m_own == 0);
    chk("gnt1", gnt1, m_own == 1);
    chk("lock_abort", lock_abort, m_abort);
    chk("ram_we", ram_we, e_we);
    chk("ram_addr", ram_addr, ea);
    chk("ram_amp", ram_amp, m ? amp1 : amp0);
    chk("ram_wd", ram_wd, m ? wd1 : wd0);
    chk("rd", rd, exp_mem[ea]);
    s_gnt0 = gnt0; s_gnt1 = gnt1; s_we = ram_we; s_abort = lock_abort; s_rd = rd;
    @(posedge clk);
    model_edge(e_we, m);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    req0 = 0; req1 = 0; lock0 = 0; lock1 = 0; we0 = 0; we1 = 0;
    amp0 = 4'hF; amp1 = 4'hF; addr0 = '0; addr1 = '0; wd0 = '0; wd1 = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    model_reset();
    #1;
    chk("rst_gnt0", gnt0, 1'b0);
    chk("rst_gnt1", gnt1, 1'b0);
    chk("rst_ram_we", ram_we, 1'b0);
    chk("rst_lock_abort", lock_abort, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [11:0] seq;
    int n0, aborts, wes;
    bit seen1;
    rst = 1'b1;
    clear_inputs();
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = 32'h0101_0101 * i ^ 32'h5A5A_0000;
      exp_mem[i] = 32'h0101_0101 * i ^ 32'h5A5A_0000;
    end
    mem[5] = 32'hDEAD_BEEF; exp_mem[5] = 32'hDEAD_BEEF;
    mem[9] = 32'hAABB_CCDD; exp_mem[9] = 32'hAABB_CCDD;
    @(negedge clk);
    do_reset();

    // Single read by master 0.
    req0 = 1; addr0 = 5;
    step();
    chk("t1_idle_gnt0", s_gnt0, 1'b0);
    step();
    chk("t1_gnt0", s_gnt0, 1'b1);
    chk("t1_rd", s_rd, 32'hDEAD_BEEF);
    chk("t1_gnt1", s_gnt1, 1'b0);

    // Simultaneous requests alternate starting with master 0.
    do_reset();
    req0 = 1; req1 = 1; addr0 = 3; addr1 = 7;
    seq = '0;
    for (int i = 0; i < 6; i++) begin
      step();
      seq = {seq[9:0], s_gnt0, s_gnt1};
    end
    chk("t2_alternate", {20'd0, seq}, {20'd0, 12'b00_10_01_10_01_10});

    // Master 1 partial write of addr 9.
    do_reset();
    req1 = 1; we1 = 1; amp1 = 4'b0011; addr1 = 9; wd1 = 32'h1234_5678;
    wes = 0;
    step(); wes += s_we;
    step(); wes += s_we;
    req1 = 0; we1 = 0;
    step(); wes += s_we;
    step(); wes += s_we;
    chk("t3_we_cycles", wes, 1);
    chk("t3_mem9", mem[9], 32'hAABB_5678);

    // Master 0 locks for five beats against a waiting master 1.
    do_reset();
    req0 = 1; lock0 = 1; req1 = 1;
    n0 = 0;
    for (int i = 0; i < 5; i++) begin step(); n0 += s_gnt0; end
    lock0 = 0;
    step(); n0 += s_gnt0;
    step();
    chk("t4_lock_beats", n0, 5);
    chk("t4_handover", s_gnt1, 1'b1);

    // Lock held forever while master 1 waits.
    do_reset();
    req0 = 1; lock0 = 1; req1 = 1;
    n0 = 0; aborts = 0; seen1 = 0;
    for (int i = 0; i < 22; i++) begin
      step();
      if (s_gnt1) seen1 = 1;
      if (!seen1) n0 += s_gnt0;
      aborts += s_abort;
      if (s_gnt1 && n0 > 0 && aborts == 1) chk("t5_abort_on_switch", s_abort, 1'b1);
    end
`ifdef DMEM_ARB_TIMEOUT_EN
    chk("t5_locked_beats", n0, MAX_LOCK);
    chk("t5_aborts", aborts, 1);
`else
    chk("t5_locked_beats", n0, 21);
    chk("t5_aborts", aborts, 0);
`endif

    // Reset in the middle of a master 1 write.
    do_reset();
    req1 = 1; we1 = 1; amp1 = 4'hF; addr1 = 20; wd1 = 32'hCAFE_F00D;
    step();
    #2;
    chk("t6_pre_gnt1", gnt1, 1'b1);
    rst = 1'b1;
    #1;
    chk("t6_gnt1_rst", gnt1, 1'b0);
    chk("t6_we_rst", ram_we, 1'b0);
    chk("t6_abort_rst", lock_abort, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    clear_inputs();
    model_reset();
    chk("t6_mem20", mem[20], exp_mem[20]);
    req0 = 1; req1 = 1;
    step();
    step();
    chk("t6_first_gnt0", s_gnt0, 1'b1);

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      req0  = ($urandom_range(0, 99) < 70);
      req1  = ($urandom_range(0, 99) < 60);
      lock0 = ($urandom_range(0, 99) < 60);
      lock1 = ($urandom_range(0, 99) < 40);
      we0   = $urandom_range(0, 1);
      we1   = $urandom_range(0, 1);
      amp0  = 4'($urandom); amp1 = 4'($urandom);
      addr0 = AW'($urandom); addr1 = AW'($urandom);
      wd0   = $urandom; wd1 = $urandom;
      step();
    end
    clear_inputs();
    step();
    for (int i = 0; i < DEPTH; i++) chk("final_mem", mem[i], exp_mem[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
